// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the pipelined core's M stage.
// Supports byte/half/word stores with lane masking, sign/zero-extended
// loads, alignment rejection and a fixed LATENCY wait before ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (array contents kept)
//   req          access request, inputs held stable until ready
//   we           1 = store, 0 = load
//   size         00 byte, 01 half, 10 word, 11 illegal
//   unsigned_ld  zero-extend byte/half loads when 1
//   addr         byte address (high bits ignored, addresses alias)
//   wd           store data, right-justified
//   rd           load result during a successful load ready cycle, else 0
//   ready        access completes (or is rejected) this cycle
//   misaligned   access rejected this cycle
module dmem_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             unsigned_ld,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             ready,
  output logic             misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_RELOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0][7:0]   mem [DEPTH];

  logic [AW-1:0]     idx;
  logic [1:0]        lane;
  logic              mis_c;
  logic              complete;
  logic [3:0]        lane_mask;
  logic [3:0][7:0]   wdata;
  logic [3:0][7:0]   word_rd;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [WIDTH-1:0]  load_val;
  logic              unused_addr;

  always_comb begin
    idx         = addr[AW+1:2];
    lane        = addr[1:0];
    unused_addr = ^addr[WIDTH-1:AW+2];
    mis_c       = (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00) ||
                  (size == 2'b11);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    misaligned = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (mis_c) begin
            ready      = 1'b1;
            misaligned = 1'b1;
          end else if (LATENCY == 0) begin
            ready    = 1'b1;
            complete = 1'b1;
          end else begin
            cnt_d   = LAT_RELOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready    = 1'b1;
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store data is replicated across lanes so the mask alone selects the target.
  always_comb begin
    lane_mask = '0;
    wdata     = wd;
    unique case (size)
      2'b00: begin
        lane_mask = 4'b0001 << lane;
        wdata     = {4{wd[7:0]}};
      end
      2'b01: begin
        lane_mask = lane[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{wd[15:0]}};
      end
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = '0;
    endcase
  end

  always_comb begin
    word_rd  = mem[idx];
    byte_sel = word_rd[lane];
    half_sel = lane[1] ? word_rd[3:2] : word_rd[1:0];
    unique case (size)
      2'b00:   load_val = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
      default: load_val = word_rd;
    endcase
    rd = (ready && !misaligned && !we) ? load_val : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array is not reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && complete && we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[idx][i] <= wdata[i];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int DEPTH = 64;
  localparam int ND    = 4;

  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] data;
    logic [31:0] exp;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, we, unsigned_ld;
  logic [1:0]    size;
  logic [31:0]   addr, wd;
  logic [ND-1:0] req;
  logic [31:0]   rd_w    [ND];
  logic          ready_w [ND];
  logic          mis_w   [ND];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  mdl [ND][4*DEPTH];

  dmem_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wd(wd), .rd(rd_w[0]), .ready(ready_w[0]), .misaligned(mis_w[0]));
  dmem_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wd(wd), .rd(rd_w[1]), .ready(ready_w[1]), .misaligned(mis_w[1]));
  dmem_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .req(req[2]), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wd(wd), .rd(rd_w[2]), .ready(ready_w[2]), .misaligned(mis_w[2]));
  dmem_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .req(req[3]), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wd(wd), .rd(rd_w[3]), .ready(ready_w[3]), .misaligned(mis_w[3]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b11);
  endfunction

  task automatic mdl_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] data);
    int b;
    b = int'(a % (4 * DEPTH));
    case (sz)
      2'b00: mdl[d][b] = data[7:0];
      2'b01: begin mdl[d][b] = data[7:0]; mdl[d][b+1] = data[15:8]; end
      default: for (int i = 0; i < 4; i++) mdl[d][b+i] = data[8*i +: 8];
    endcase
  endtask

  function automatic logic [31:0] mdl_load(input int d, input logic [1:0] sz, input logic u,
                                           input logic [31:0] a);
    int b;
    logic [7:0]  v8;
    logic [15:0] v16;
    b = int'(a % (4 * DEPTH));
    case (sz)
      2'b00: begin v8 = mdl[d][b]; return u ? {24'h0, v8} : {{24{v8[7]}}, v8}; end
      2'b01: begin
        v16 = {mdl[d][b+1], mdl[d][b]};
        return u ? {16'h0, v16} : {{16{v16[15]}}, v16};
      end
      default: return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
    endcase
  endfunction

  // Drives one access on DUT d, counts stall cycles until ready (bounded),
  // and returns the outputs seen in the ready cycle. Called near a negedge.
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] data, input bit keep,
                        output int stalls, output logic [31:0] rd_o, output logic mis_o);
    we = w; size = sz; unsigned_ld = u; addr = a; wd = data; req[d] = 1'b1;
    stalls = 0;
    #1;
    while (!ready_w[d] && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd_o  = rd_w[d];
    mis_o = mis_w[d];
    if (w && stalls < 40 && !is_mis(sz, a)) mdl_store(d, sz, a, data);
    @(negedge clk);
    if (!keep) req[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = '0; wd = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ready_w[d] !== 1'b0 || mis_w[d] !== 1'b0 || rd_w[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset d%0d: ready=%b mis=%b rd=%h, want 0 0 00000000",
                 d, ready_w[d], mis_w[d], rd_w[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    op_t tbl [2];
    int st;
    logic [31:0] r, e;
    logic m;
    tbl = '{ {1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0},
             {1'b0, 2'd2, 1'b0, 32'h10, 32'h0,       32'hDEADBEEF} };
    for (int i = 0; i < 2; i++) begin
      if (!tbl[i].w) exp_q.push_back(tbl[i].exp);
      access(0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].data, 0, st, r, m);
      checks++;
      if (st !== 1 || m !== 1'b0) begin
        errors++;
        $display("FAIL word_stall op%0d: stalls=%0d mis=%b, want 1 0", i, st, m);
      end
      e = tbl[i].w ? 32'h0 : exp_q.pop_front();
      checks++;
      if (r !== e) begin errors++; $display("FAIL word_rd op%0d: got %h want %h", i, r, e); end
    end
    #1;
    checks++;
    if (ready_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL word_ready_after: got %b want 0", ready_w[0]);
    end
  endtask

  task automatic test_byte_lanes();
    op_t tbl [9];
    int st;
    logic [31:0] r, e;
    logic m;
    tbl = '{ {1'b1, 2'd2, 1'b0, 32'h14, 32'h0,  32'h0},
             {1'b1, 2'd0, 1'b0, 32'h16, 32'hAB, 32'h0},
             {1'b0, 2'd2, 1'b0, 32'h14, 32'h0,  32'h00AB0000},
             {1'b0, 2'd0, 1'b0, 32'h16, 32'h0,  32'hFFFFFFAB},
             {1'b0, 2'd0, 1'b1, 32'h16, 32'h0,  32'h000000AB},
             {1'b1, 2'd0, 1'b0, 32'h17, 32'hFFFFFF7F, 32'h0},
             {1'b0, 2'd0, 1'b0, 32'h17, 32'h0,  32'h0000007F},
             {1'b1, 2'd0, 1'b0, 32'h14, 32'h80, 32'h0},
             {1'b0, 2'd2, 1'b1, 32'h14, 32'h0,  32'h7FAB0080} };
    for (int i = 0; i < 9; i++) begin
      if (!tbl[i].w) exp_q.push_back(tbl[i].exp);
      access(0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].data, 0, st, r, m);
      checks++;
      if (st !== 1 || m !== 1'b0) begin
        errors++;
        $display("FAIL byte_stall op%0d: stalls=%0d mis=%b, want 1 0", i, st, m);
      end
      e = tbl[i].w ? 32'h0 : exp_q.pop_front();
      checks++;
      if (r !== e) begin errors++; $display("FAIL byte_rd op%0d: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_half();
    op_t tbl [8];
    int st;
    logic [31:0] r, e;
    logic m;
    tbl = '{ {1'b1, 2'd2, 1'b0, 32'h18, 32'h11223344, 32'h0},
             {1'b1, 2'd1, 1'b0, 32'h1A, 32'h00008001, 32'h0},
             {1'b0, 2'd1, 1'b0, 32'h1A, 32'h0, 32'hFFFF8001},
             {1'b0, 2'd1, 1'b1, 32'h1A, 32'h0, 32'h00008001},
             {1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 32'h80013344},
             {1'b0, 2'd1, 1'b0, 32'h18, 32'h0, 32'h00003344},
             {1'b1, 2'd1, 1'b0, 32'h18, 32'hFFFF7FFE, 32'h0},
             {1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 32'h80017FFE} };
    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].w) exp_q.push_back(tbl[i].exp);
      access(0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].data, 0, st, r, m);
      checks++;
      if (st !== 1 || m !== 1'b0) begin
        errors++;
        $display("FAIL half_stall op%0d: stalls=%0d mis=%b, want 1 0", i, st, m);
      end
      e = tbl[i].w ? 32'h0 : exp_q.pop_front();
      checks++;
      if (r !== e) begin errors++; $display("FAIL half_rd op%0d: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_misaligned();
    op_t tbl [6];
    int st;
    logic [31:0] r, e;
    logic m;
    tbl = '{ {1'b1, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0},
             {1'b1, 2'd1, 1'b0, 32'h13, 32'h0,        32'h0},
             {1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        32'h0},
             {1'b1, 2'd3, 1'b0, 32'h20, 32'h0,        32'h0},
             {1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0},
             {1'b0, 2'd2, 1'b0, 32'h22, 32'h0,        32'h0} };
    access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h55AA55AA, 0, st, r, m);
    for (int i = 0; i < 6; i++) begin
      access(0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].data, 0, st, r, m);
      checks++;
      if (st !== 0 || m !== 1'b1 || r !== 32'h0) begin
        errors++;
        $display("FAIL misaligned op%0d: stalls=%0d mis=%b rd=%h, want 0 1 00000000", i, st, m, r);
      end
    end
    access(3, 1'b1, 2'd2, 1'b0, 32'h41, 32'h0, 0, st, r, m);
    checks++;
    if (st !== 0 || m !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_lat15: stalls=%0d mis=%b, want 0 1", st, m);
    end
    exp_q.push_back(32'hDEADBEEF);
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, st, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL misaligned_mem10: got %h want %h", r, e); end
    exp_q.push_back(32'h55AA55AA);
    access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, st, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL misaligned_mem20: got %h want %h", r, e); end
  endtask

  task automatic test_latency();
    int st, lat;
    logic [31:0] r, e, a, data;
    logic m;
    logic [1:0] szs [3];
    szs = '{2'd2, 2'd0, 2'd1};
    for (int d = 1; d < ND; d++) begin
      lat  = lat_of(d);
      a    = 32'h40 + 32'(8 * d);
      data = $urandom;
      access(d, 1'b1, 2'd2, 1'b0, a, data, 0, st, r, m);
      checks++;
      if (st !== lat) begin errors++; $display("FAIL lat_store d%0d: stalls=%0d want %0d", d, st, lat); end
      // Three loads back to back with req held high throughout.
      for (int k = 0; k < 3; k++) begin
        exp_q.push_back(mdl_load(d, szs[k], 1'(k == 1), a + 32'(k)));
        access(d, 1'b0, szs[k], 1'(k == 1), a + 32'(k), 32'h0, k < 2, st, r, m);
        e = exp_q.pop_front();
        checks++;
        if (st !== lat || r !== e) begin
          errors++;
          $display("FAIL lat_load d%0d k%0d: stalls=%0d rd=%h, want %0d %h", d, k, st, r, lat, e);
        end
      end
    end
  endtask

  task automatic test_alias();
    int st;
    logic [31:0] r, e;
    logic m;
    exp_q.push_back(32'hDEADBEEF);
    access(0, 1'b0, 2'd2, 1'b0, 32'h10 + 32'(4 * DEPTH), 32'h0, 0, st, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL alias_load: got %h want %h", r, e); end
    access(0, 1'b1, 2'd2, 1'b0, 32'h10 + 32'(8 * DEPTH), 32'h2468ACE0, 0, st, r, m);
    exp_q.push_back(32'h2468ACE0);
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, st, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL alias_store: got %h want %h", r, e); end
  endtask

  task automatic test_abort_and_reset();
    int st, n;
    logic [31:0] r, e;
    logic m;
    // Abort: req dropped while waiting, no write.
    access(2, 1'b1, 2'd2, 1'b0, 32'h50, 32'hA5A5A5A5, 0, st, r, m);
    we = 1'b1; size = 2'd2; addr = 32'h50; wd = 32'h0; req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'hA5A5A5A5);
    access(2, 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 0, st, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e || st !== 3) begin
      errors++;
      $display("FAIL abort: rd=%h stalls=%0d, want %h 3", r, st, e);
    end
    // Reset while waiting: outputs clear, next access sees the full latency.
    access(2, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 0, st, r, m);
    we = 1'b1; size = 2'd2; addr = 32'h30; wd = 32'h12345678; req[2] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ready_w[2] !== 1'b0 || mis_w[2] !== 1'b0 || rd_w[2] !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ready=%b mis=%b rd=%h, want 0 0 00000000",
               ready_w[2], mis_w[2], rd_w[2]);
    end
    rst = 1'b0;
    exp_q.push_back(32'hCAFEF00D);
    access(2, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, st, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e || st !== 3) begin
      errors++;
      $display("FAIL rst_mid_load: rd=%h stalls=%0d, want %h 3", r, st, e);
    end
    // Reset during the ready cycle of a store suppresses the write.
    we = 1'b1; size = 2'd2; addr = 32'h30; wd = 32'h12345678; req[2] = 1'b1;
    n = 0;
    #1;
    while (!ready_w[2] && n < 40) begin n++; @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req[2] = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'hCAFEF00D);
    access(2, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, st, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e || n !== 3) begin
      errors++;
      $display("FAIL rst_ready_store: rd=%h wait=%0d, want %h 3", r, n, e);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_half();
    test_misaligned();
    test_latency();
    test_alias();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
